// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped cache sequencer with tag/valid/dirty state and byte-wide write-back/refill bursts
module dm_cache_ctrl #(
  parameter int TAG_W = 16,
  parameter int INDEX_W = 8,
  parameter int OFFSET_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [31:0]         cpu_addr,
  input  logic [7:0]          cpu_wdata,
  output logic [7:0]          cpu_rdata,
  output logic                cpu_ready,
  output logic                hit,
  output logic                miss,
  output logic [INDEX_W-1:0]  da_index,
  output logic [OFFSET_W-1:0] da_offset,
  output logic                da_we,
  output logic [7:0]          da_wdata,
  input  logic [7:0]          da_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [7:0]          mem_wdata,
  input  logic [7:0]          mem_rdata,
  input  logic                mem_ack
);
  localparam int LINES = 2 ** INDEX_W;
  typedef enum logic [2:0] {IDLE, LOOKUP, RESPOND, WRITEBACK, REFILL} state_t;
  state_t               r_state;
  logic                 r_we;
  logic [31:0]          r_addr;
  logic [7:0]           r_wdata, r_rdata;
  logic [OFFSET_W-1:0]  r_cnt;
  logic [LINES-1:0]     r_valid, r_dirty;
  logic [TAG_W-1:0]     r_tag [LINES];
  logic [TAG_W-1:0]     w_tag;
  logic [INDEX_W-1:0]   w_idx;
  logic [OFFSET_W-1:0]  w_off;
  logic                 w_hit, w_wb, w_rf, w_last, w_fill_done;
  assign w_tag = r_addr[31 -: TAG_W];
  assign w_idx = r_addr[OFFSET_W +: INDEX_W];
  assign w_off = r_addr[OFFSET_W-1:0];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_wb = r_state == WRITEBACK;
  assign w_rf = r_state == REFILL;
  assign w_last = &r_cnt;
  assign w_fill_done = w_rf && mem_ack && w_last;
  assign hit = (r_state == LOOKUP) && w_hit;
  assign miss = (r_state == LOOKUP) && !w_hit;
  assign cpu_ready = r_state == RESPOND;
  assign cpu_rdata = cpu_ready ? r_rdata : 8'h00;
  assign mem_req = w_wb || w_rf;
  assign mem_we = w_wb;
  assign mem_addr = w_wb ? {r_tag[w_idx], w_idx, r_cnt} : w_rf ? {w_tag, w_idx, r_cnt} : 32'h0;
  assign mem_wdata = w_wb ? da_rdata : 8'h00;
  assign da_index = (r_state == IDLE) ? '0 : w_idx;
  assign da_offset = mem_req ? r_cnt : (r_state == IDLE) ? '0 : w_off;
  assign da_we = (cpu_ready && r_we) || (w_rf && mem_ack);
  assign da_wdata = !da_we ? 8'h00 : w_rf ? mem_rdata : r_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
      r_cnt   <= '0;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      case (r_state)
        IDLE: if (cpu_req) begin
          r_we    <= cpu_we;
          r_addr  <= cpu_addr;
          r_wdata <= cpu_wdata;
          r_state <= LOOKUP;
        end
        LOOKUP: begin
          r_cnt <= '0;
          if (w_hit) begin
            r_rdata <= r_we ? 8'h00 : da_rdata;
            r_state <= RESPOND;
          end else
            r_state <= (r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : REFILL;
        end
        RESPOND: begin
          if (r_we) r_dirty[w_idx] <= 1'b1;
          r_state <= IDLE;
        end
        WRITEBACK: if (mem_ack) begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_dirty[w_idx] <= 1'b0;
            r_state <= REFILL;
          end
        end
        REFILL: if (mem_ack) begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
            r_state <= LOOKUP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // Tags need no reset: they are only trusted where the matching valid bit is set
  always_ff @(posedge clk)
    if (!rst && w_fill_done) r_tag[w_idx] <= w_tag;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: randomized check of dm_cache_ctrl against a flat-memory reference of what the CPU should see
module tb_dm_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready, hit, miss;
  logic [7:0]  da_index, da_offset, da_wdata, da_rdata;
  logic        da_we;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ack = 1'b0;
  dm_cache_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .hit(hit), .miss(miss),
    .da_index(da_index), .da_offset(da_offset), .da_we(da_we), .da_wdata(da_wdata),
    .da_rdata(da_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );
  always #5 clk = ~clk;
  logic [7:0]  da_mem [256][256];
  logic [7:0]  mem [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic        rv [256];
  logic        rd [256];
  logic [15:0] rt [256];
  int          checks = 0, failures = 0, waits = 0, wc = 0, hits, misses;
  logic        cur_we = 1'b0, prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [7:0]  prev_wd = 8'h00;
  logic [31:0] wb_a [$];
  logic [31:0] rf_a [$];
  logic [7:0]  wb_d [$];
  assign da_rdata = da_mem[da_index][da_offset];
  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a[7:0];
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a[7:0];
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Memory: ack after `waits` idle cycles per beat, data settled just after each edge
  initial forever begin
    @(posedge clk);
    #1;
    if (mem_req) begin
      if (wc == waits) begin mem_ack = 1'b1; wc = 0; end
      else begin mem_ack = 1'b0; wc++; end
    end else begin
      mem_ack = 1'b0;
      wc = 0;
    end
    mem_rdata = mem_rd(mem_addr);
  end
  // Called once per negedge: applies committed writes and records beats
  task automatic step();
    if (mem_req && prev_req && !prev_ack) begin
      chk("hold_addr", mem_addr, prev_addr);
      chk("hold_wdata", mem_wdata, prev_wd);
      chk("hold_we", mem_we, prev_we);
    end
    chk("da_we_legal", da_we && !((cpu_ready && cur_we) || (mem_req && !mem_we && mem_ack)), 0);
    if (da_we) da_mem[da_index][da_offset] = da_wdata;
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        wb_a.push_back(mem_addr);
        wb_d.push_back(mem_wdata);
      end else rf_a.push_back(mem_addr);
    end
    hits += hit;
    misses += miss;
    {prev_req, prev_ack, prev_we, prev_addr, prev_wd} = {mem_req, mem_ack, mem_we, mem_addr, mem_wdata};
  endtask
  task automatic req(input logic we, input logic [31:0] a, input logic [7:0] wd);
    logic [7:0]  idx;
    logic [15:0] tg, otag;
    logic        eh, ew, done;
    logic [7:0]  rdata;
    int          cyc, nwb;
    idx = a[15:8];
    tg = a[31:16];
    otag = rt[idx];
    eh = rv[idx] && rt[idx] == tg;
    ew = !eh && rv[idx] && rd[idx];
    nwb = ew ? 256 : 0;
    hits = 0;
    misses = 0;
    wb_a.delete();
    wb_d.delete();
    rf_a.delete();
    rdata = 8'h00;
    @(negedge clk);
    cur_we = we;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      step();
      if (cpu_ready) begin done = 1'b1; rdata = cpu_rdata; end
    end
    cpu_req = 1'b0;
    chk("timeout", done, 1);
    chk("hit_pulses", hits, 1);
    chk("miss_pulses", misses, eh ? 0 : 1);
    chk("latency", cyc, eh ? 2 : 3 + (nwb + 256) * (waits + 1));
    chk("rdata", rdata, we ? 8'h00 : ref_rd(a));
    chk("wb_beats", wb_a.size(), nwb);
    chk("rf_beats", rf_a.size(), eh ? 0 : 256);
    foreach (wb_a[k]) begin
      chk("wb_addr", wb_a[k], {otag, idx, 8'(k)});
      chk("wb_data", wb_d[k], ref_rd(wb_a[k]));
    end
    foreach (rf_a[k]) chk("rf_addr", rf_a[k], {tg, idx, 8'(k)});
    if (we) ref_mem[a] = wd;
    rd[idx] = (eh && rd[idx]) || we;
    rv[idx] = 1'b1;
    rt[idx] = tg;
  endtask
  initial begin
    logic [15:0] tgs [3];
    int cyc;
    tgs = '{16'h1111, 16'h2222, 16'h3333};
    for (int i = 0; i < 256; i++) begin
      rv[i] = 1'b0; rd[i] = 1'b0; rt[i] = 16'h0;
      for (int j = 0; j < 256; j++) da_mem[i][j] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {cpu_ready, hit, miss, mem_req, mem_we, da_we}, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_da", {da_index, da_offset, da_wdata}, 0);
    rst = 1'b0;
    req(1'b0, 32'h1234_0507, 8'h00);
    req(1'b0, 32'h1234_05FF, 8'h00);
    req(1'b1, 32'h1234_0510, 8'hA5);
    chk("da_write", da_mem[8'h05][8'h10], 8'hA5);
    req(1'b0, 32'h9999_0510, 8'h00);
    req(1'b0, 32'h1234_0510, 8'h00);
    waits = 3;
    req(1'b1, 32'h5555_0722, 8'h3C);
    req(1'b0, 32'h6666_0722, 8'h00);
    req(1'b0, 32'h5555_0722, 8'h00);
    for (int n = 0; n < 16; n++) begin
      waits = $urandom_range(0, 1);
      req(1'($urandom_range(0, 1)),
          {tgs[$urandom_range(0, 2)], 8'($urandom_range(1, 2)), 8'($urandom_range(0, 255))},
          8'($urandom));
    end
    waits = 0;
    @(negedge clk);
    cur_we = 1'b0;
    rf_a.delete();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h7777_4033;
    cyc = 0;
    while (rf_a.size() < 100 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      step();
    end
    chk("rst_reach_beat", rf_a.size(), 100);
    rst = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    step();
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_ctrl", {cpu_ready, hit, miss, da_we}, 0);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin rv[i] = 1'b0; rd[i] = 1'b0; end
    ref_mem.delete();
    foreach (mem[a]) ref_mem[a] = mem[a];
    req(1'b0, 32'h7777_4033, 8'h00);
    req(1'b0, 32'h1234_05FF, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
